signed_div_sequencer: RTL
=========================

Name: signed_div_sequencer

Overview:
- Front-end sequencer that sits directly upstream of the unsigned shift-subtract divider datapath and its controller.
- Accepts signed or unsigned operand pairs on a valid/ready handshake and converts signed operands to magnitudes.
- Pulses the divider's load/reset input, holds run until the divider reports ready, then sign-corrects the quotient and remainder.
- Presents the result on a valid/ready output handshake, with divide-by-zero, overflow and timeout flags.

Parameters:
- WIDTH, 32: operand, quotient and remainder width.
- TIMEOUT, 40: maximum RUN-state cycles to wait for div_rdy before aborting.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_signed  in  1  1 = signed division, 0 = unsigned; sampled with operands.
- in_dividend  in  WIDTH  dividend.
- in_divisor  in  WIDTH  divisor.
- div_load  out  1  one-cycle pulse to the divider's reset/load input; loads operands.
- div_run  out  1  run enable to the divider.
- div_dividend  out  WIDTH  unsigned dividend magnitude, stable from LOAD until IDLE.
- div_divisor  out  WIDTH  unsigned divisor magnitude, stable from LOAD until IDLE.
- div_rdy  in  1  divider done.
- div_quotient  in  WIDTH  unsigned quotient from divider.
- div_remainder  in  WIDTH  unsigned remainder from divider.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_quotient  out  WIDTH  final quotient.
- out_remainder  out  WIDTH  final remainder.
- out_dz  out  1  divisor was zero.
- out_ovf  out  1  signed most-negative / -1.
- out_timeout  out  1  divider never reported ready.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is applied on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - in_ready = 1.
  - div_load = 0, div_run = 0.
  - out_valid = 0.
  - all data outputs and flags = 0.
  - timeout counter = 0.
  - rst mid-operation aborts with no result emitted.
- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE (in_ready = 1): on in_valid && in_ready:
  - Latch sign_a = in_signed & dividend MSB and sign_b = in_signed & divisor MSB.
  - Latch magnitudes: two's-complement negate if the sign bit is set; the most-negative value maps to 2^(WIDTH-1) unsigned.
  - If divisor == 0: go to DONE with quotient = all ones, remainder = raw dividend, out_dz = 1. The divider is not started.
  - Otherwise go to LOAD.
- LOAD: div_load = 1 for exactly one cycle; next state RUN.
- RUN:
  - div_run = 1 and the counter increments each cycle.
  - If div_rdy is sampled 1, go to FIX; div_run drops in FIX.
  - If the counter reaches TIMEOUT first, go to DONE with q = 0, r = 0, out_timeout = 1.
- FIX: register the corrected results; next state DONE.
  - quotient = sign_a^sign_b ? -div_quotient : div_quotient.
  - remainder = sign_a ? -div_remainder : div_remainder.
  - out_ovf = in_signed && dividend == 1 followed by WIDTH-1 zeros && divisor == all ones; the quotient wraps to 0x80000000.
- DONE: out_valid = 1; outputs and flags hold stable until out_ready. On out_valid && out_ready, go to IDLE and clear out_valid and flags.
- Latency:
  - If div_rdy is first sampled high at cycle R, out_valid = 1 at R+2.
  - Divide-by-zero: out_valid = 1 the cycle after acceptance.
- in_ready = 1 only in IDLE. No new operands are accepted while a result is pending; there is no pipelining.
- div_rdy is ignored outside RUN.
- Arithmetic is modulo 2^WIDTH. Unsigned mode never negates and never sets out_ovf.

Decomposition:
- Shared package div_pkg:
  - state encoding constants (IDLE = 0 through DONE = 4).
  - WIDTH default.
  - divide-by-zero constants.
- One natural sub-module, sign_mag (combinational): abs value and conditional negate. It is instantiated for operand conversion and for result correction.

Test Plan:
- Unsigned 7 / 2 with a divider model (rdy after 35 run cycles) -> q = 3, r = 1; out_valid exactly 2 cycles after rdy; exactly one div_load pulse.
- Signed 0xFFFFFFF9 (-7) / 2 -> div_dividend = 7; q = 0xFFFFFFFD, r = 0xFFFFFFFF. Then 7 / 0xFFFFFFFE -> q = 0xFFFFFFFD, r = 1.
- 5 / 0 (signed or unsigned) -> no div_load or div_run; out_valid next cycle; q = 0xFFFFFFFF, r = 5, out_dz = 1.
- Signed 0x80000000 / 0xFFFFFFFF -> q = 0x80000000, r = 0, out_ovf = 1. The same operands unsigned -> q = 0, r = 0x80000000, out_ovf = 0.
- div_rdy held 0 -> after 40 RUN cycles: out_valid = 1, out_timeout = 1, q = r = 0, div_run = 0.
- Backpressure and reset:
  - out_ready held 0 for 10 cycles -> outputs stable and in_ready = 0 throughout.
  - rst asserted in RUN -> next cycle IDLE, div_run = 0, out_valid = 0, in_ready = 1.

Source files
------------

// File: rtl/signed_div_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// signed_div_sequencer_pkg
// Shared definitions for the signed division front-end sequencer:
//   - default operand width and RUN-state timeout,
//   - sequencer state encoding (IDLE = 0 .. DONE = 4),
//   - divide-by-zero result constants.
// No ports (package).
// -----------------------------------------------------------------------------
package signed_div_sequencer_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_TIMEOUT = 40;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } seq_state_e;

    // Divide-by-zero: quotient is every bit set, remainder is the raw dividend.
    localparam logic DZ_QUOTIENT_BIT = 1'b1;
    localparam logic DZ_FLAG         = 1'b1;

endpackage

// File: rtl/signed_div_sequencer_if.sv
// -----------------------------------------------------------------------------
// signed_div_sequencer_if
// Operand-in and result-out handshake bundle of the signed division sequencer.
//   in_valid/in_ready      operand pair handshake
//   in_signed              1 = signed division, sampled with the operands
//   in_dividend/in_divisor operands
//   out_valid/out_ready    result handshake
//   out_quotient/out_remainder  final results
//   out_dz/out_ovf/out_timeout  divide-by-zero, overflow and timeout flags
// Modports: master = operand producer / result consumer, slave = sequencer.
// -----------------------------------------------------------------------------
interface signed_div_sequencer_if
    import signed_div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             out_dz;
    logic             out_ovf;
    logic             out_timeout;

    modport master (
        output in_valid, in_signed, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder,
               out_dz, out_ovf, out_timeout
    );

    modport slave (
        input  in_valid, in_signed, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder,
               out_dz, out_ovf, out_timeout
    );
endinterface

// File: rtl/signed_div_sequencer_sign_mag.sv
// -----------------------------------------------------------------------------
// signed_div_sequencer_sign_mag
// Combinational conditional two's-complement negate. Used both to turn signed
// operands into magnitudes and to sign-correct the divider's results.
//   val_i  operand
//   neg_i  1 = negate
//   res_o  neg_i ? -val_i : val_i (modulo 2^WIDTH)
// -----------------------------------------------------------------------------
module signed_div_sequencer_sign_mag
    import signed_div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Negating the most-negative value wraps to itself, which read as
    // unsigned is exactly its magnitude 2^(WIDTH-1).
    always_comb begin
        if (neg_i) begin
            res_o = ~val_i + ONE;
        end else begin
            res_o = val_i;
        end
    end
endmodule

// File: rtl/signed_div_sequencer.sv
// -----------------------------------------------------------------------------
// signed_div_sequencer
// Front end of an unsigned shift-subtract divider. Accepts a signed or unsigned
// operand pair, hands the divider operand magnitudes, pulses its load input,
// holds run until it reports ready (or a timeout expires), sign-corrects the
// quotient/remainder and presents the result with dz/ovf/timeout flags.
//   clk, rst        clock, synchronous active-high reset
//   bus             operand/result handshakes (slave side)
//   div_load        one-cycle load pulse to the divider
//   div_run         divider run enable
//   div_dividend    dividend magnitude to the divider
//   div_divisor     divisor magnitude to the divider
//   div_rdy         divider done (only looked at in RUN)
//   div_quotient    unsigned quotient from the divider
//   div_remainder   unsigned remainder from the divider
// -----------------------------------------------------------------------------
module signed_div_sequencer
    import signed_div_sequencer_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    signed_div_sequencer_if.slave bus,
    output logic                  div_load,
    output logic                  div_run,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic                  div_rdy,
    input  logic [WIDTH-1:0]      div_quotient,
    input  logic [WIDTH-1:0]      div_remainder
);
    localparam int               CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ZERO        = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_MAG     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] DZ_QUOTIENT = {WIDTH{DZ_QUOTIENT_BIT}};

    seq_state_e       state_q, state_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;
    logic             in_ready_q;
    logic             div_load_q;
    logic             div_run_q;
    logic             out_valid_q;

    logic             in_sign_a_s;
    logic             in_sign_b_s;
    logic [WIDTH-1:0] in_mag_a_s;
    logic [WIDTH-1:0] in_mag_b_s;
    logic [WIDTH-1:0] fix_quo_s;
    logic [WIDTH-1:0] fix_rem_s;

    assign in_sign_a_s = bus.in_signed & bus.in_dividend[WIDTH-1];
    assign in_sign_b_s = bus.in_signed & bus.in_divisor[WIDTH-1];

    signed_div_sequencer_sign_mag #(.WIDTH(WIDTH)) u_mag_a (
        .val_i(bus.in_dividend), .neg_i(in_sign_a_s), .res_o(in_mag_a_s)
    );
    signed_div_sequencer_sign_mag #(.WIDTH(WIDTH)) u_mag_b (
        .val_i(bus.in_divisor), .neg_i(in_sign_b_s), .res_o(in_mag_b_s)
    );
    // Quotient is negative when operand signs differ; remainder follows the dividend.
    signed_div_sequencer_sign_mag #(.WIDTH(WIDTH)) u_fix_quo (
        .val_i(div_quotient), .neg_i(sign_a_q ^ sign_b_q), .res_o(fix_quo_s)
    );
    signed_div_sequencer_sign_mag #(.WIDTH(WIDTH)) u_fix_rem (
        .val_i(div_remainder), .neg_i(sign_a_q), .res_o(fix_rem_s)
    );

    // Next-state and next-result logic of the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        tmo_d    = tmo_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (bus.in_valid) begin
                    sign_a_d = in_sign_a_s;
                    sign_b_d = in_sign_b_s;
                    mag_a_d  = in_mag_a_s;
                    mag_b_d  = in_mag_b_s;
                    if (bus.in_divisor == ZERO) begin
                        // Divider is never started for a zero divisor.
                        state_d = ST_DONE;
                        quo_d   = DZ_QUOTIENT;
                        rem_d   = bus.in_dividend;
                        dz_d    = DZ_FLAG;
                        ovf_d   = 1'b0;
                        tmo_d   = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                // A ready seen on the last allowed cycle still wins over the timeout.
                if (div_rdy) begin
                    state_d = ST_FIX;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    quo_d   = ZERO;
                    rem_d   = ZERO;
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                quo_d   = fix_quo_s;
                rem_d   = fix_rem_s;
                dz_d    = 1'b0;
                tmo_d   = 1'b0;
                // Only the signed most-negative / -1 pair has these magnitudes and signs.
                ovf_d   = sign_a_q & sign_b_q & (mag_a_q == MIN_MAG) & (mag_b_q == ONE);
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                    quo_d   = ZERO;
                    rem_d   = ZERO;
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, datapath and output registers; handshake/control outputs are
    // decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            mag_a_q     <= ZERO;
            mag_b_q     <= ZERO;
            cnt_q       <= CNT_ZERO;
            quo_q       <= ZERO;
            rem_q       <= ZERO;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            div_load_q  <= 1'b0;
            div_run_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            in_ready_q  <= (state_d == ST_IDLE);
            div_load_q  <= (state_d == ST_LOAD);
            div_run_q   <= (state_d == ST_RUN);
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_quotient  = quo_q;
    assign bus.out_remainder = rem_q;
    assign bus.out_dz        = dz_q;
    assign bus.out_ovf       = ovf_q;
    assign bus.out_timeout   = tmo_q;
    assign div_load          = div_load_q;
    assign div_run           = div_run_q;
    assign div_dividend      = mag_a_q;
    assign div_divisor       = mag_b_q;
endmodule
